// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared constants for the instruction/data memory port arbiter:
//   - default address/data widths (PC and instruction width of the core)
//   - 2-bit FSM state encodings ARB_IDLE / ARB_ISSUE / ARB_WAIT
//   - owner codes ARB_OWN_IF / ARB_OWN_LSU
//   - sat_inc8: saturating 8-bit increment used by the starvation counter
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    localparam int PC_WIDTH    = 32;
    localparam int INSTR_WIDTH = 32;

    localparam logic [1:0] ARB_IDLE  = 2'd0;
    localparam logic [1:0] ARB_ISSUE = 2'd1;
    localparam logic [1:0] ARB_WAIT  = 2'd2;

    localparam logic ARB_OWN_IF  = 1'b0;
    localparam logic ARB_OWN_LSU = 1'b1;

    // Counter must not wrap back to zero and silently re-arm priority
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : (v + 8'd1);
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// -----------------------------------------------------------------------------
// mem_arb_pick
// Grant selection for the memory port arbiter. LSU has priority over fetch;
// a fetch is never granted in a cycle where if_flush is high.
//
// Optional macro MEM_ARB_STARVE_GUARD_EN: an 8-bit counter tracks LSU grants
// made while a fetch was waiting; once it equals STARVE_LIMIT the next grant
// goes to the fetch path if it is requesting.
//
// Ports:
//   clk, rst    clock, async active-low reset (counter only)
//   grant_en    arbiter is idle and may grant this cycle
//   if_valid    fetch request pending
//   if_flush    fetch redirect (blocks a fetch grant this cycle)
//   lsu_valid   data request pending
//   grant_if    fetch request granted this cycle
//   grant_lsu   data request granted this cycle
// -----------------------------------------------------------------------------
module mem_arb_pick
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
)(
    input  logic clk,
    input  logic rst,
    input  logic grant_en,
    input  logic if_valid,
    input  logic if_flush,
    input  logic lsu_valid,
    output logic grant_if,
    output logic grant_lsu
);

    logic if_elig_s;

    assign if_elig_s = if_valid & ~if_flush;

`ifdef MEM_ARB_STARVE_GUARD_EN

    logic [7:0] starve_cnt_q;
    logic [7:0] starve_cnt_d;
    logic       force_if_s;

    // Grant selection; a saturated LSU streak hands one grant to the fetch
    always_comb begin
        force_if_s = (starve_cnt_q == STARVE_LIMIT[7:0]) & if_elig_s;
        grant_lsu  = grant_en & lsu_valid & ~force_if_s;
        grant_if   = grant_en & if_elig_s & (~lsu_valid | force_if_s);
    end

    // Streak counter: counts LSU grants that made a live fetch wait
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (grant_if) begin
            starve_cnt_d = 8'd0;
        end else if (grant_lsu) begin
            if (if_elig_s) begin
                starve_cnt_d = sat_inc8(starve_cnt_q);
            end else if (!if_valid) begin
                starve_cnt_d = 8'd0;
            end else begin
                // fetch pending but flushed: neither waiting nor idle
                starve_cnt_d = starve_cnt_q;
            end
        end else begin
            starve_cnt_d = starve_cnt_q;
        end
    end

    // Streak counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt_q <= 8'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

`else

    logic unused_s;

    assign unused_s = &{1'b0, clk, rst, STARVE_LIMIT[0]};

    // Strict LSU priority
    always_comb begin
        grant_lsu = grant_en & lsu_valid;
        grant_if  = grant_en & if_elig_s & ~lsu_valid;
    end

`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port memory between the fetch path and the LSU. One
// transaction is outstanding at a time: IDLE grants and latches a request,
// ISSUE presents it to memory until accepted, WAIT holds until the memory
// response, which is returned to the owner as a one-cycle pulse.
// A fetch redirect (if_flush) while a fetch is in flight suppresses its
// response; the memory transaction itself still completes.
//
// Optional macro MEM_ARB_STARVE_GUARD_EN (see mem_arb_pick): bounds how many
// LSU grants in a row a waiting fetch can lose.
//
// Ports:
//   clk, rst                         clock, async active-low reset
//   if_req_valid/ready/addr          fetch request handshake
//   if_flush                         fetch redirect
//   if_rsp_valid/data                fetch response pulse, data held between
//   lsu_req_valid/ready/addr/wen/wdata/wmask   data request handshake
//   lsu_rsp_valid/rdata              data response pulse (also write ack)
//   mem_req_valid/ready/addr/wen/wdata/wmask   registered memory request
//   mem_rsp_valid/rdata              memory response
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int          ADDR_W       = PC_WIDTH,
    parameter int          DATA_W       = INSTR_WIDTH,
    parameter int unsigned STARVE_LIMIT = 4
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req_valid,
    output logic                if_req_ready,
    input  logic [ADDR_W-1:0]   if_req_addr,
    input  logic                if_flush,
    output logic                if_rsp_valid,
    output logic [DATA_W-1:0]   if_rsp_data,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_req_addr,
    input  logic                lsu_req_wen,
    input  logic [DATA_W-1:0]   lsu_req_wdata,
    input  logic [DATA_W/8-1:0] lsu_req_wmask,
    output logic                lsu_rsp_valid,
    output logic [DATA_W-1:0]   lsu_rsp_rdata,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic                mem_req_wen,
    output logic [DATA_W-1:0]   mem_req_wdata,
    output logic [DATA_W/8-1:0] mem_req_wmask,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rsp_rdata
);

    localparam int MASK_W = DATA_W / 8;

    logic [1:0]        state_q,         state_d;
    logic              owner_q,         owner_d;
    logic              drop_q,          drop_d;
    logic              mem_req_valid_q, mem_req_valid_d;
    logic [ADDR_W-1:0] addr_q,          addr_d;
    logic              wen_q,           wen_d;
    logic [DATA_W-1:0] wdata_q,         wdata_d;
    logic [MASK_W-1:0] wmask_q,         wmask_d;
    logic              if_rsp_valid_q,  if_rsp_valid_d;
    logic [DATA_W-1:0] if_rsp_data_q,   if_rsp_data_d;
    logic              lsu_rsp_valid_q, lsu_rsp_valid_d;
    logic [DATA_W-1:0] lsu_rsp_rdata_q, lsu_rsp_rdata_d;

    logic grant_en_s;
    logic grant_if_s;
    logic grant_lsu_s;
    logic flush_hit_s;

    assign grant_en_s  = (state_q == ARB_IDLE);
    assign flush_hit_s = if_flush & (owner_q == ARB_OWN_IF);

    mem_arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_pick (
        .clk       (clk),
        .rst       (rst),
        .grant_en  (grant_en_s),
        .if_valid  (if_req_valid),
        .if_flush  (if_flush),
        .lsu_valid (lsu_req_valid),
        .grant_if  (grant_if_s),
        .grant_lsu (grant_lsu_s)
    );

    // Readies are the only combinational outputs; forced low while in reset
    assign if_req_ready  = grant_if_s  & rst;
    assign lsu_req_ready = grant_lsu_s & rst;

    assign mem_req_valid = mem_req_valid_q;
    assign mem_req_addr  = addr_q;
    assign mem_req_wen   = wen_q;
    assign mem_req_wdata = wdata_q;
    assign mem_req_wmask = wmask_q;
    assign if_rsp_valid  = if_rsp_valid_q;
    assign if_rsp_data   = if_rsp_data_q;
    assign lsu_rsp_valid = lsu_rsp_valid_q;
    assign lsu_rsp_rdata = lsu_rsp_rdata_q;

    // Transaction FSM, request latch, drop flag and response capture
    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        drop_d          = drop_q;
        mem_req_valid_d = mem_req_valid_q;
        addr_d          = addr_q;
        wen_d           = wen_q;
        wdata_d         = wdata_q;
        wmask_d         = wmask_q;
        if_rsp_valid_d  = 1'b0;
        if_rsp_data_d   = if_rsp_data_q;
        lsu_rsp_valid_d = 1'b0;
        lsu_rsp_rdata_d = lsu_rsp_rdata_q;
        case (state_q)
            ARB_IDLE: begin
                drop_d = 1'b0;
                if (grant_lsu_s) begin
                    state_d         = ARB_ISSUE;
                    owner_d         = ARB_OWN_LSU;
                    mem_req_valid_d = 1'b1;
                    addr_d          = lsu_req_addr;
                    wen_d           = lsu_req_wen;
                    wdata_d         = lsu_req_wdata;
                    wmask_d         = lsu_req_wmask;
                end else if (grant_if_s) begin
                    // fetches are always reads: no enable, no byte lanes
                    state_d         = ARB_ISSUE;
                    owner_d         = ARB_OWN_IF;
                    mem_req_valid_d = 1'b1;
                    addr_d          = if_req_addr;
                    wen_d           = 1'b0;
                    wdata_d         = {DATA_W{1'b0}};
                    wmask_d         = {MASK_W{1'b0}};
                end else begin
                    mem_req_valid_d = 1'b0;
                end
            end
            ARB_ISSUE: begin
                if (flush_hit_s) begin
                    drop_d = 1'b1;
                end else begin
                    drop_d = drop_q;
                end
                if (mem_req_ready) begin
                    state_d         = ARB_WAIT;
                    mem_req_valid_d = 1'b0;
                end else begin
                    mem_req_valid_d = 1'b1;
                end
            end
            ARB_WAIT: begin
                if (mem_rsp_valid) begin
                    state_d = ARB_IDLE;
                    drop_d  = 1'b0;
                    if (owner_q == ARB_OWN_LSU) begin
                        lsu_rsp_valid_d = 1'b1;
                        lsu_rsp_rdata_d = mem_rsp_rdata;
                    end else if (!(drop_q | flush_hit_s)) begin
                        if_rsp_valid_d = 1'b1;
                        if_rsp_data_d  = mem_rsp_rdata;
                    end else begin
                        // redirected fetch: swallow the response, keep old data
                        if_rsp_valid_d = 1'b0;
                    end
                end else if (flush_hit_s) begin
                    drop_d = 1'b1;
                end else begin
                    drop_d = drop_q;
                end
            end
            default: begin
                state_d         = ARB_IDLE;
                drop_d          = 1'b0;
                mem_req_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= ARB_IDLE;
            owner_q         <= ARB_OWN_IF;
            drop_q          <= 1'b0;
            mem_req_valid_q <= 1'b0;
            addr_q          <= {ADDR_W{1'b0}};
            wen_q           <= 1'b0;
            wdata_q         <= {DATA_W{1'b0}};
            wmask_q         <= {MASK_W{1'b0}};
            if_rsp_valid_q  <= 1'b0;
            if_rsp_data_q   <= {DATA_W{1'b0}};
            lsu_rsp_valid_q <= 1'b0;
            lsu_rsp_rdata_q <= {DATA_W{1'b0}};
        end else begin
            state_q         <= state_d;
            owner_q         <= owner_d;
            drop_q          <= drop_d;
            mem_req_valid_q <= mem_req_valid_d;
            addr_q          <= addr_d;
            wen_q           <= wen_d;
            wdata_q         <= wdata_d;
            wmask_q         <= wmask_d;
            if_rsp_valid_q  <= if_rsp_valid_d;
            if_rsp_data_q   <= if_rsp_data_d;
            lsu_rsp_valid_q <= lsu_rsp_valid_d;
            lsu_rsp_rdata_q <= lsu_rsp_rdata_d;
        end
    end

endmodule
